// File: rtl/audio_voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler family: FSM state encoding,
// timing constants and accumulator width derivation.
package audio_voice_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_SCALE   = 3'd2,
      S_WRITE   = 3'd3,
      S_GAP     = 3'd4
   } sched_state_t;

   // Cycles spent after the write strobe so the registered FIFO-space flag
   // from the audio controller has caught up before the next admission.
   localparam int GAP_CYCLES = 2;

   // Clip counter sticks here instead of wrapping.
   localparam logic [7:0] CLIP_MAX = 8'hFF;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2_f(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v / 2;
      end
      return r;
   endfunction

   // Accumulator width: enough headroom to sum every voice at full scale,
   // plus one guard bit.
   function automatic int acc_width(input int sample_w, input int num_voices);
      return sample_w + clog2_f(num_voices) + 1;
   endfunction

endpackage

// File: rtl/audio_voice_scheduler_sat_shift_scaler.sv
// Combinational volume scaler: arithmetic right shift of the mixed sum,
// saturation into the signed output range, and mute forcing.
module sat_shift_scaler #(
   parameter int ACC_W = 28,
   parameter int OUT_W = 32
) (
   input  logic signed [ACC_W-1:0] i_acc,
   input  logic [2:0]              i_shift,
   input  logic                    i_mute,
   output logic [OUT_W-1:0]        o_result,
   output logic                    o_clip
);

   logic signed [ACC_W-1:0] w_shifted;
   logic [OUT_W-1:0]        w_fit;
   logic [OUT_W-1:0]        w_limit;
   logic                    w_over;

   assign w_shifted = i_acc >>> i_shift;

   generate
      if (OUT_W >= ACC_W) begin : g_no_sat
         // Output is wide enough for any sum: plain sign extension.
         assign w_fit  = OUT_W'(w_shifted);
         assign w_over = 1'b0;
      end else begin : g_sat
         // Value fits only if every bit from the output sign bit upward agrees.
         logic [ACC_W-OUT_W:0] w_top;
         assign w_top  = w_shifted[ACC_W-1:OUT_W-1];
         assign w_fit  = w_shifted[OUT_W-1:0];
         assign w_over = !((&w_top) || !(|w_top));
      end
   endgenerate

   assign w_limit = w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};

   // Pick saturated or in-range value; mute overrides and suppresses clip reporting.
   always_comb begin
      o_result = w_over ? w_limit : w_fit;
      o_clip   = w_over;
      if (i_mute) begin
         o_result = '0;
         o_clip   = 1'b0;
      end
   end

endmodule

// File: rtl/audio_voice_scheduler.sv
// Per-frame voice mixer feeding the codec audio-out write port: polls each
// voice once per frame, scales and saturates the sum, then strobes one write.
module audio_voice_scheduler
   import audio_voice_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int SAMPLE_W   = 24,
   parameter int OUT_W      = 32
) (
   input  logic                           CLOCK_50,
   input  logic                           resetn,
   input  logic                           enable,
   input  logic                           mute,
   input  logic [2:0]                     vol_shift,
   input  logic [NUM_VOICES-1:0]          voice_active,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   output logic                           voice_step,
   input  logic                           audio_out_allowed,
   output logic                           write_audio_out,
   output logic [OUT_W-1:0]               left_channel_audio_out,
   output logic [OUT_W-1:0]               right_channel_audio_out,
   output logic                           busy,
   output logic [7:0]                     clip_count
);

   localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
   localparam int IDX_W = clog2_f(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [1:0]       GAP_LAST = 2'(GAP_CYCLES - 1);

   sched_state_t            r_state;
   logic [IDX_W-1:0]        r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic [1:0]              r_gap_cnt;
   logic                    r_step;
   logic                    r_write;
   logic [OUT_W-1:0]        r_out;
   logic [7:0]              r_clip_count;

   logic signed [SAMPLE_W-1:0] w_samples [NUM_VOICES];
   logic signed [ACC_W-1:0]    w_addend;
   logic [OUT_W-1:0]           w_scaled;
   logic                       w_clip;

   generate
      for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
         assign w_samples[gi] = voice_sample[gi*SAMPLE_W +: SAMPLE_W];
      end
   endgenerate

   // Voice owned by the current COLLECT cycle, sign-extended; gated voices add nothing.
   always_comb begin
      w_addend = '0;
      if (voice_active[r_idx]) begin
         w_addend = ACC_W'(w_samples[r_idx]);
      end
   end

   sat_shift_scaler #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_scaler (
      .i_acc    (r_acc),
      .i_shift  (vol_shift),
      .i_mute   (mute),
      .o_result (w_scaled),
      .o_clip   (w_clip)
   );

   // Frame sequencer: admission, accumulation, scaling, write strobe, settle gap.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_acc        <= '0;
         r_gap_cnt    <= '0;
         r_step       <= 1'b0;
         r_write      <= 1'b0;
         r_out        <= '0;
         r_clip_count <= '0;
      end else begin
         r_step  <= 1'b0;
         r_write <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // FIFO space is only trusted at admission; a started frame always finishes.
               if (enable && audio_out_allowed) begin
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_state <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               r_acc <= r_acc + w_addend;
               if (r_idx == LAST_IDX) begin
                  r_state <= S_SCALE;
                  r_step  <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_SCALE: begin
               r_out <= w_scaled;
               if (w_clip && (r_clip_count != CLIP_MAX)) begin
                  r_clip_count <= r_clip_count + 8'd1;
               end
               r_write <= 1'b1;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_gap_cnt <= '0;
               r_state   <= S_GAP;
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign voice_step              = r_step;
   assign write_audio_out         = r_write;
   assign left_channel_audio_out  = r_out;
   assign right_channel_audio_out = r_out;
   assign busy                    = (r_state != S_IDLE);
   assign clip_count              = r_clip_count;

endmodule
